// File: rtl/dmem_responder.sv
// dmem_responder -- memory-side end of the core load/store interface.
//
// Accepts one request at a time over a valid/ready handshake, optionally
// stalls WAIT_CYCLES extra cycles, then returns a single-cycle response
// pulse. Stores commit on the acceptance edge with RV32I byte/half lane
// placement; loads are read on the edge that enters RESP and are sign- or
// zero-extended before being returned.
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_addr            byte address
//   req_size            0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned        loads: 1 zero-extend, 0 sign-extend
//   req_wdata           right-justified store data
//   rsp_valid           one-cycle response pulse
//   rsp_rdata           extended load data (0 for stores and faults)
//   rsp_err             access fault, qualified by rsp_valid
//
// Build option
//   DMEM_MISALIGN_CHK_EN  misaligned half/word accesses fault instead of
//                         being forced to natural alignment.

// One byte lane of the storage array. Not reset.
module dmem_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(64'(DEPTH_WORDS) * 4);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  req_t       live, held, cur;
  logic       accept;

  assign live   = '{we: req_we, addr: req_addr, size: req_size,
                    uns: req_unsigned, wdata: req_wdata};
  assign accept = req_valid & req_ready;
  // With zero wait states the response is produced on the acceptance edge,
  // before the request has been captured, so decode the live inputs there.
  assign cur    = (state == S_IDLE) ? live : held;

  // ---------------------------------------------------------------- decode
  logic [31:0]         off;
  logic                in_range, fault;
  logic [AW-1:0]       idx;
  logic [1:0]          lo;
  logic [3:0]          lane_we;
  logic [3:0][7:0]     lane_wd;
  logic [3:0][7:0]     rword;
  logic [7:0]          rbyte;
  logic [15:0]         rhalf;
  logic [31:0]         rd_val;
`ifdef DMEM_MISALIGN_CHK_EN
  logic                misalign;
`endif

  always_comb begin
    off      = cur.addr - BASE_ADDR;
    // off wraps when addr < BASE_ADDR, so the lower bound is checked directly.
    in_range = (cur.addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    idx      = off[AW+1:2];

    lo = cur.addr[1:0];
    case (cur.size)
      2'd1:    lo[0] = 1'b0;
      2'd2:    lo    = 2'b00;
      default: ;
    endcase

`ifdef DMEM_MISALIGN_CHK_EN
    misalign = ((cur.size == 2'd1) && cur.addr[0]) ||
               ((cur.size == 2'd2) && (cur.addr[1:0] != 2'b00));
    fault    = !in_range || (cur.size == 2'd3) || misalign;
`else
    fault    = !in_range || (cur.size == 2'd3);
`endif

    // Data is replicated across lanes; the enables pick the target lanes.
    lane_we = 4'b0000;
    lane_wd = cur.wdata;
    case (cur.size)
      2'd0: begin
        lane_we = 4'b0001 << lo;
        lane_wd = {4{cur.wdata[7:0]}};
      end
      2'd1: begin
        lane_we = lo[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{cur.wdata[15:0]}};
      end
      2'd2:    lane_we = 4'b1111;
      default: lane_we = 4'b0000;
    endcase
    if (!(accept && cur.we && !fault)) lane_we = 4'b0000;

    rbyte = rword[lo];
    rhalf = lo[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};
    case (cur.size)
      2'd0:    rd_val = cur.uns ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'd1:    rd_val = cur.uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: rd_val = rword;
    endcase
    if (fault || cur.we) rd_val = 32'h0;
  end

  // ---------------------------------------------------------------- storage
  for (genvar l = 0; l < 4; l++) begin : g_lane
    dmem_lane #(.AW(AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[l]),
      .idx   (idx),
      .wdata (lane_wd[l]),
      .rdata (rword[l])
    );
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      held      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // Ready comes up one edge after reset release, then stays high
          // in IDLE until a request is taken.
          req_ready <= 1'b1;
          if (accept) begin
            held      <= live;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_val;
              rsp_err   <= fault;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_val;
            rsp_err   <= fault;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) driven by
// directed vectors; expected responses, including the cycle they must
// appear on, go into per-instance queues checked by independent monitors.
module tb_dmem_responder;
  localparam int W0 = 0;
  localparam int W1 = 3;

  logic        clk = 1'b0;
  logic [1:0]  reset;
  logic [1:0]  req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_err;
  logic [31:0] req_addr [2];
  logic [1:0]  req_size [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(W0)) u_d0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(W1)) u_d1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  // ------------------------------------------------------------ monitors
  always @(negedge clk) begin
    if (rsp_valid[0]) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp dut0: cyc %0d rdata %h err %b", cyc, rsp_rdata[0], rsp_err[0]);
      end else begin
        e0 = q0.pop_front();
        if (rsp_rdata[0] !== e0.rdata || rsp_err[0] !== e0.err || cyc != e0.cyc || req_ready[0] !== 1'b0) begin
          errors++;
          $display("FAIL rsp dut0: got rdata %h err %b cyc %0d ready %b, expected rdata %h err %b cyc %0d ready 0",
                   rsp_rdata[0], rsp_err[0], cyc, req_ready[0], e0.rdata, e0.err, e0.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid[1]) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp dut1: cyc %0d rdata %h err %b", cyc, rsp_rdata[1], rsp_err[1]);
      end else begin
        e1 = q1.pop_front();
        if (rsp_rdata[1] !== e1.rdata || rsp_err[1] !== e1.err || cyc != e1.cyc || req_ready[1] !== 1'b0) begin
          errors++;
          $display("FAIL rsp dut1: got rdata %h err %b cyc %0d ready %b, expected rdata %h err %b cyc %0d ready 0",
                   rsp_rdata[1], rsp_err[1], cyc, req_ready[1], e1.rdata, e1.err, e1.cyc);
        end
      end
    end
  end

  // ------------------------------------------------------------ helpers
  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(int d, logic [31:0] rd, logic er, int c);
    exp_t e;
    e.rdata = rd; e.err = er; e.cyc = c;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int d, logic we, logic [31:0] a, logic [1:0] sz, logic u, logic [31:0] wd);
    req_we[d] = we; req_addr[d] = a; req_size[d] = sz;
    req_unsigned[d] = u; req_wdata[d] = wd; req_valid[d] = 1'b1;
  endtask

  // Garbage on the request bus after acceptance must not leak into the response.
  task automatic scramble(int d);
    req_valid[d] = 1'b0;
    req_we[d] = 1'($urandom); req_addr[d] = $urandom;
    req_size[d] = 2'($urandom); req_unsigned[d] = 1'($urandom); req_wdata[d] = $urandom;
  endtask

  task automatic wait_ready(int d);
    int n = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (req_ready[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout dut%0d: ready %b expected 1", d, req_ready[d]);
    end
  endtask

  task automatic wait_rsp(int d);
    int n = 0;
    while (qsize(d) != 0 && n < 60) begin @(negedge clk); n++; end
    if (qsize(d) != 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout dut%0d: %0d responses missing, expected 0", d, qsize(d));
      if (d == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic issue(int d, logic we, logic [31:0] a, logic [1:0] sz, logic u,
                       logic [31:0] wd, logic [31:0] exp_rd, logic exp_err);
    wait_ready(d);
    drive(d, we, a, sz, u, wd);
    push(d, exp_rd, exp_err, cyc + 1 + ((d == 0) ? W0 : W1));
    @(posedge clk); #1;
    scramble(d);
    wait_rsp(d);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int c;
    reset = 2'b11;
    req_valid = '0; req_we = '0; req_unsigned = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_size[i] = '0; req_wdata[i] = '0;
    end

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready%0d", i), 32'(req_ready[i]), 32'h0);
      chk($sformatf("reset_valid%0d", i), 32'(rsp_valid[i]), 32'h0);
      chk($sformatf("reset_rdata%0d", i), rsp_rdata[i], 32'h0);
      chk($sformatf("reset_err%0d", i), 32'(rsp_err[i]), 32'h0);
    end
    reset = 2'b00;

    // ---- zero wait states: lane placement and extension
    issue(0, 1, 32'h10, 2, 0, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 0, 32'h10, 2, 0, 32'h0,        32'hDEADBEEF, 0);
    issue(0, 1, 32'h13, 0, 0, 32'hFFFFFF80, 32'h0, 0);
    issue(0, 0, 32'h13, 0, 0, 32'h0,        32'hFFFFFF80, 0);
    issue(0, 0, 32'h13, 0, 1, 32'h0,        32'h00000080, 0);
    issue(0, 0, 32'h10, 2, 0, 32'h0,        32'h80ADBEEF, 0);
    issue(0, 1, 32'h10, 1, 0, 32'hABCD1234, 32'h0, 0);
    issue(0, 0, 32'h10, 1, 1, 32'h0,        32'h00001234, 0);
    issue(0, 0, 32'h10, 2, 1, 32'h0,        32'h80AD1234, 0);
    issue(0, 0, 32'h12, 1, 0, 32'h0,        32'hFFFF80AD, 0);
    issue(0, 0, 32'h11, 0, 0, 32'h0,        32'h00000012, 0);

    // ---- faults
    issue(0, 1, 32'h0,    2, 0, 32'hA5A50F0F, 32'h0, 0);
    issue(0, 1, 32'h1000, 2, 0, 32'h00000055, 32'h0, 1);
    issue(0, 0, 32'h0,    2, 0, 32'h0,        32'hA5A50F0F, 0);
    issue(0, 0, 32'h0,    3, 0, 32'h0,        32'h0, 1);

    // ---- misaligned word load
    issue(0, 1, 32'h10, 2, 0, 32'h11223344, 32'h0, 0);
`ifdef DMEM_MISALIGN_CHK_EN
    issue(0, 0, 32'h12, 2, 0, 32'h0, 32'h0, 1);
`else
    issue(0, 0, 32'h12, 2, 0, 32'h0, 32'h11223344, 0);
`endif

    // ---- three wait states: ready pattern with valid held high
    issue(1, 1, 32'h10, 2, 0, 32'hDEADBEEF, 32'h0, 0);
    wait_ready(1);
    c = cyc;
    drive(1, 0, 32'h10, 2, 0, 32'h0);
    push(1, 32'hDEADBEEF, 0, c + 4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("wait_ready_low_n%0d", k), 32'(req_ready[1]), 32'h0);
    end
    @(negedge clk);
    chk("wait_ready_high_n5", 32'(req_ready[1]), 32'h1);
    push(1, 32'hDEADBEEF, 0, c + 9);
    @(posedge clk); #1;
    scramble(1);
    wait_rsp(1);
    issue(1, 0, 32'h100, 2, 0, 32'h0, 32'h0, 1);

    // ---- reset while waiting: store stays, no response
    wait_ready(1);
    c = cyc;
    drive(1, 1, 32'h20, 2, 0, 32'hCAFE0001);
    @(posedge clk); #1;
    scramble(1);
    while (cyc < c + 2) @(negedge clk);
    reset[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_ready%0d", k), 32'(req_ready[1]), 32'h0);
      chk($sformatf("rst_valid%0d", k), 32'(rsp_valid[1]), 32'h0);
    end
    chk("rst_rdata", rsp_rdata[1], 32'h0);
    reset[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready[1]), 32'h1);
    issue(1, 0, 32'h20, 2, 0, 32'h0, 32'hCAFE0001, 0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
